vga_scanout_engine: RTL and testbench

Parametrised framebuffer scanout engine: the next generation of the VGA video path, replacing the fixed 640x480 / 2x-scale / 4 bpp chain that runs from the timing generator through the VRAM interface. It generates VGA timing, issues word reads to a synchronous VRAM port and unpacks 1/2/4/8 bpp pixels into a palette index, with sync outputs aligned to the pixel pipeline. New capability: double-buffered page flip, applied atomically at the frame boundary. It also raises a vertical-blank pulse for the CPU side. It sits between the 25 MHz PLL output, VRAM port B and the EGA palette logic.

---
 rtl/tau_video_pkg.sv | 46 ++++
 rtl/vga_timing_gen.sv | 63 ++++++
 rtl/vga_scanout_engine.sv | 164 ++++++++++++++++
 tb/tb_vga_scanout_engine.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tau_video_pkg.sv
// Shared video types, default 640x480 timing and derived-geometry helpers
// for the framebuffer scanout path.
package tau_video_pkg;

    localparam int unsigned DEF_H_ACTIVE    = 640;
    localparam int unsigned DEF_H_FRONT     = 16;
    localparam int unsigned DEF_H_SYNC      = 96;
    localparam int unsigned DEF_H_BACK      = 48;
    localparam int unsigned DEF_V_ACTIVE    = 480;
    localparam int unsigned DEF_V_FRONT     = 10;
    localparam int unsigned DEF_V_SYNC      = 2;
    localparam int unsigned DEF_V_BACK      = 33;
    localparam int unsigned DEF_SCALE_SHIFT = 1;
    localparam int unsigned DEF_BPP         = 4;
    localparam int unsigned DEF_WORD_WIDTH  = 16;
    localparam int unsigned DEF_ADDR_WIDTH  = 16;

    typedef enum logic {
        FLIP_IDLE,
        FLIP_ARMED
    } flip_state_t;

    // Sync/active/vblank strobes travelling alongside the pixel pipeline.
    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic active;
        logic vblank;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, active: 1'b0, vblank: 1'b0};

    function automatic int unsigned calc_ppw(input int unsigned word_width, input int unsigned bpp);
        return word_width / bpp;
    endfunction

    function automatic int unsigned calc_wpl(input int unsigned h_active, input int unsigned scale_shift,
                                             input int unsigned ppw);
        return (h_active >> scale_shift) / ppw;
    endfunction

    function automatic bit params_legal(input int unsigned bpp, input int unsigned word_width);
        return (bpp == 1 || bpp == 2 || bpp == 4 || bpp == 8) && (word_width != 0) && (word_width % bpp == 0);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Stage-0 raster counters plus raw (undelayed) sync, active, flip-point and
// vblank-start strobes decoded from them.
module vga_timing_gen
    import tau_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter int unsigned H_W      = $clog2(H_ACTIVE + H_FRONT + H_SYNC + H_BACK),
    parameter int unsigned V_W      = $clog2(V_ACTIVE + V_FRONT + V_SYNC + V_BACK)
) (
    input  logic           i_clock,
    input  logic           i_reset,
    output logic [H_W-1:0] o_h_count,
    output logic [V_W-1:0] o_v_count,
    output logic           o_hsync_n,
    output logic           o_vsync_n,
    output logic           o_active,
    output logic           o_flip_point,
    output logic           o_vblank_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    logic [H_W-1:0] r_h_count;
    logic [V_W-1:0] r_v_count;
    logic           w_h_last;
    logic           w_v_last;

    assign w_h_last = (32'(r_h_count) == H_TOTAL - 1);
    assign w_v_last = (32'(r_v_count) == V_TOTAL - 1);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_h_count <= '0;
            r_v_count <= '0;
        end else if (w_h_last) begin
            r_h_count <= '0;
            r_v_count <= w_v_last ? '0 : r_v_count + 1'b1;
        end else begin
            r_h_count <= r_h_count + 1'b1;
        end
    end

    // Comparisons are done at 32 bits so a sync edge equal to the total never truncates.
    assign o_hsync_n = !((32'(r_h_count) >= H_ACTIVE + H_FRONT) &&
                         (32'(r_h_count) <  H_ACTIVE + H_FRONT + H_SYNC));
    assign o_vsync_n = !((32'(r_v_count) >= V_ACTIVE + V_FRONT) &&
                         (32'(r_v_count) <  V_ACTIVE + V_FRONT + V_SYNC));

    assign o_h_count      = r_h_count;
    assign o_v_count      = r_v_count;
    assign o_active       = (32'(r_h_count) < H_ACTIVE) && (32'(r_v_count) < V_ACTIVE);
    assign o_flip_point   = w_h_last && w_v_last;
    assign o_vblank_start = (32'(r_v_count) == V_ACTIVE) && (r_h_count == '0);

endmodule

// File: rtl/vga_scanout_engine.sv
// Framebuffer scanout: timing -> VRAM word address -> pixel unpack, with
// 3-clock aligned sync and a frame-boundary double-buffer page flip.
module vga_scanout_engine
    import tau_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT     = DEF_H_FRONT,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BACK      = DEF_H_BACK,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT     = DEF_V_FRONT,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BACK      = DEF_V_BACK,
    parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter int unsigned BPP         = DEF_BPP,
    parameter int unsigned WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    input  logic [WORD_WIDTH-1:0] vram_data,
    input  logic [ADDR_WIDTH-1:0] flip_base,
    input  logic                  flip_req,
    output logic                  flip_pending,
    output logic                  flip_done,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  in_active_area,
    output logic [BPP-1:0]        pixel_index,
    output logic                  vblank_pulse
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned PPW     = calc_ppw(WORD_WIDTH, BPP);
    localparam int unsigned WPL     = calc_wpl(H_ACTIVE, SCALE_SHIFT, PPW);
    localparam int unsigned SUB_W   = (PPW > 1) ? $clog2(PPW) : 1;

    if (!params_legal(BPP, WORD_WIDTH)) begin : g_bad_params
        $error("vga_scanout_engine: BPP must be 1, 2, 4 or 8 and divide WORD_WIDTH");
    end

    logic [H_W-1:0] w_h_count;
    logic [V_W-1:0] w_v_count;
    logic           w_hsync_n;
    logic           w_vsync_n;
    logic           w_active;
    logic           w_flip_point;
    logic           w_vblank;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .H_W      (H_W),
        .V_W      (V_W)
    ) u_timing (
        .i_clock        (clock),
        .i_reset        (reset),
        .o_h_count      (w_h_count),
        .o_v_count      (w_v_count),
        .o_hsync_n      (w_hsync_n),
        .o_vsync_n      (w_vsync_n),
        .o_active       (w_active),
        .o_flip_point   (w_flip_point),
        .o_vblank_start (w_vblank)
    );

    flip_state_t           r_flip_state;
    logic [ADDR_WIDTH-1:0] r_active_base;
    logic [ADDR_WIDTH-1:0] r_pending_base;

    // A request landing on the flip point bypasses the pending register entirely.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_flip_state   <= FLIP_IDLE;
            r_active_base  <= '0;
            r_pending_base <= '0;
            flip_done      <= 1'b0;
        end else begin
            flip_done <= 1'b0;
            if (w_flip_point && flip_req) begin
                r_active_base <= flip_base;
                r_flip_state  <= FLIP_IDLE;
                flip_done     <= 1'b1;
            end else if (w_flip_point && r_flip_state == FLIP_ARMED) begin
                r_active_base <= r_pending_base;
                r_flip_state  <= FLIP_IDLE;
                flip_done     <= 1'b1;
            end else if (flip_req) begin
                r_pending_base <= flip_base;
                r_flip_state   <= FLIP_ARMED;
            end
        end
    end

    assign flip_pending = (r_flip_state == FLIP_ARMED);

    logic [H_W-1:0]        w_xs;
    logic [V_W-1:0]        w_ys;
    logic [ADDR_WIDTH-1:0] w_line_off;
    logic [ADDR_WIDTH-1:0] w_word_off;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [SUB_W-1:0]      w_sub;

    assign w_xs       = w_h_count >> SCALE_SHIFT;
    assign w_ys       = w_v_count >> SCALE_SHIFT;
    assign w_line_off = ADDR_WIDTH'(w_ys) * ADDR_WIDTH'(WPL);
    assign w_word_off = ADDR_WIDTH'(32'(w_xs) / PPW);
    assign w_addr     = r_active_base + w_line_off + w_word_off;
    assign w_sub      = SUB_W'(32'(w_xs) % PPW);

    ctl_t             w_ctl0;
    ctl_t             r_ctl1;
    ctl_t             r_ctl2;
    logic [SUB_W-1:0] r_sub1;
    logic [SUB_W-1:0] r_sub2;

    assign w_ctl0 = '{hsync_n: w_hsync_n, vsync_n: w_vsync_n, active: w_active, vblank: w_vblank};

    // Pixel 0 of a word sits in the MSBs, so shift left by k pixels and take the top.
    logic [WORD_WIDTH-1:0] w_shifted;
    logic [BPP-1:0]        w_pixel;

    assign w_shifted = vram_data << (32'(r_sub2) * BPP);
    assign w_pixel   = w_shifted[WORD_WIDTH-1 -: BPP];

    always_ff @(posedge clock) begin
        if (reset) begin
            vram_addr      <= '0;
            r_sub1         <= '0;
            r_sub2         <= '0;
            r_ctl1         <= CTL_IDLE;
            r_ctl2         <= CTL_IDLE;
            pixel_index    <= '0;
            hsync          <= 1'b1;
            vsync          <= 1'b1;
            in_active_area <= 1'b0;
            vblank_pulse   <= 1'b0;
        end else begin
            if (w_active) begin
                vram_addr <= w_addr;
                r_sub1    <= w_sub;
            end
            r_ctl1         <= w_ctl0;
            r_sub2         <= r_sub1;
            r_ctl2         <= r_ctl1;
            pixel_index    <= r_ctl2.active ? w_pixel : '0;
            hsync          <= r_ctl2.hsync_n;
            vsync          <= r_ctl2.vsync_n;
            in_active_area <= r_ctl2.active;
            vblank_pulse   <= r_ctl2.vblank;
        end
    end

endmodule

// File: tb/tb_vga_scanout_engine.sv
// Directed bench for vga_scanout_engine on a shrunken raster (48x18 clocks),
// with a cycle model feeding a 3-deep expected-output queue.
module tb_vga_scanout_engine;

    localparam int HA = 32, HF = 4, HS = 8, HB = 4, HT = 48;
    localparam int VA = 12, VF = 2, VS = 2, VB = 2, VT = 18;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       vb;
        logic [3:0] pix;
    } exp_t;

    localparam exp_t RST_E = '{hs: 1'b1, vs: 1'b1, act: 1'b0, vb: 1'b0, pix: 4'h0};

    logic clock = 1'b0;
    always #20 clock = ~clock;

    logic        reset;
    logic [15:0] vram_addr, vram_data, flip_base;
    logic        flip_req, flip_pending, flip_done, hsync, vsync, in_active_area, vblank_pulse;
    logic [3:0]  pixel_index;

    logic [15:0] b_addr, b_data, b_flip_base;
    logic        b_flip_req, b_pend, b_done, b_hs, b_vs, b_act, b_vb;
    logic [7:0]  b_pix;

    function automatic logic [15:0] vram_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h1234;
    endfunction

    always_ff @(posedge clock) vram_data <= vram_word(vram_addr);
    always_ff @(posedge clock) b_data <= 16'hABCD;

    vga_scanout_engine #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SCALE_SHIFT(1), .BPP(4), .WORD_WIDTH(16), .ADDR_WIDTH(16)
    ) dut (
        .clock(clock), .reset(reset), .vram_addr(vram_addr), .vram_data(vram_data),
        .flip_base(flip_base), .flip_req(flip_req), .flip_pending(flip_pending),
        .flip_done(flip_done), .hsync(hsync), .vsync(vsync),
        .in_active_area(in_active_area), .pixel_index(pixel_index), .vblank_pulse(vblank_pulse)
    );

    vga_scanout_engine #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SCALE_SHIFT(0), .BPP(8), .WORD_WIDTH(16), .ADDR_WIDTH(16)
    ) dut_b (
        .clock(clock), .reset(reset), .vram_addr(b_addr), .vram_data(b_data),
        .flip_base(b_flip_base), .flip_req(b_flip_req), .flip_pending(b_pend),
        .flip_done(b_done), .hsync(b_hs), .vsync(b_vs),
        .in_active_area(b_act), .pixel_index(b_pix), .vblank_pulse(b_vb)
    );

    int n_cmp = 0;
    int n_err = 0;

    int          m_h, m_v;
    logic [15:0] m_base, m_pbase, m_addr, mb_addr;
    bit          m_pend, m_done;
    exp_t        q[$];
    logic [7:0]  qb[$];
    int          n_hs_low, n_vs_low, n_act, n_vb, n_done;
    logic [3:0]  first_pix [8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_hs_low = 0; n_vs_low = 0; n_act = 0; n_vb = 0; n_done = 0;
    endtask

    // One clock: model the stage-0 cycle, clock the DUT, then compare.
    task automatic step(input bit req, input logic [15:0] base);
        exp_t        e, got;
        logic [7:0]  eb;
        bit          act, fp;
        int          sub;
        logic [15:0] word;
        flip_req  = req;
        flip_base = base;
        act = (m_h < HA) && (m_v < VA);
        fp  = (m_h == HT - 1) && (m_v == VT - 1);
        sub = 0;
        if (act) begin
            m_addr  = m_base + 16'((m_v >> 1) * 4 + (m_h >> 1) / 4);
            sub     = (m_h >> 1) % 4;
            mb_addr = 16'(m_v * 16 + m_h / 2);
        end
        word  = vram_word(m_addr);
        e.hs  = !(m_h >= HA + HF && m_h < HA + HF + HS);
        e.vs  = !(m_v >= VA + VF && m_v < VA + VF + VS);
        e.act = act;
        e.vb  = (m_v == VA) && (m_h == 0);
        e.pix = act ? 4'(word >> (12 - 4 * sub)) : 4'h0;
        q.push_back(e);
        qb.push_back(act ? (((m_h % 2) == 0) ? 8'hAB : 8'hCD) : 8'h00);
        m_done = 1'b0;
        if (fp && req) begin
            m_base = base; m_pend = 1'b0; m_done = 1'b1;
        end else if (fp && m_pend) begin
            m_base = m_pbase; m_pend = 1'b0; m_done = 1'b1;
        end else if (req) begin
            m_pbase = base; m_pend = 1'b1;
        end
        if (m_h == HT - 1) begin
            m_h = 0;
            m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
            m_h++;
        end
        @(posedge clock);
        #1;
        flip_req = 1'b0;
        got = q.pop_front();
        eb  = qb.pop_front();
        check("vram_addr", vram_addr, m_addr);
        check("flip_pending", flip_pending, m_pend);
        check("flip_done", flip_done, m_done);
        check("hsync", hsync, got.hs);
        check("vsync", vsync, got.vs);
        check("in_active_area", in_active_area, got.act);
        check("vblank_pulse", vblank_pulse, got.vb);
        check("pixel_index", pixel_index, got.pix);
        check("b_vram_addr", b_addr, mb_addr);
        check("b_pixel_index", b_pix, eb);
        check("b_hsync", b_hs, got.hs);
        check("b_vsync", b_vs, got.vs);
        check("b_active", b_act, got.act);
        check("b_vblank", b_vb, got.vb);
        check("b_flip_pending", b_pend, 0);
        check("b_flip_done", b_done, 0);
        n_hs_low += (hsync === 1'b0) ? 1 : 0;
        n_vs_low += (vsync === 1'b0) ? 1 : 0;
        n_act    += (in_active_area === 1'b1) ? 1 : 0;
        n_vb     += (vblank_pulse === 1'b1) ? 1 : 0;
        n_done   += (flip_done === 1'b1) ? 1 : 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0000);
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(m_h == h && m_v == v) && n <= FRAME) begin
            step(1'b0, 16'h0000);
            n++;
        end
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b1;
        flip_req = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
        check("rst_vram_addr", vram_addr, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_active", in_active_area, 0);
        check("rst_pixel", pixel_index, 0);
        check("rst_flip_pending", flip_pending, 0);
        check("rst_flip_done", flip_done, 0);
        check("rst_vblank", vblank_pulse, 0);
        reset = 1'b0;
        m_h = 0; m_v = 0; m_base = '0; m_pbase = '0; m_pend = 1'b0; m_done = 1'b0;
        m_addr = '0; mb_addr = '0;
        q.delete();
        qb.delete();
        repeat (2) begin
            q.push_back(RST_E);
            qb.push_back(8'h00);
        end
    endtask

    initial begin
        reset = 1'b1; flip_req = 1'b0; flip_base = '0;
        b_flip_req = 1'b0; b_flip_base = '0;
        do_reset(3);

        // Word 0 of the frame reads back 0x1234; each nibble spans two clocks.
        run(2);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0000);
            check("first_word_pixel", pixel_index, first_pix[i]);
        end
        run_to(0, 0);

        clear_stats();
        run(FRAME);
        check("hsync_low_per_frame", n_hs_low, HS * VT);
        check("vsync_low_per_frame", n_vs_low, VS * HT);
        check("active_per_frame", n_act, HA * VA);
        check("vblank_per_frame", n_vb, 1);

        // Mid-frame flip: held pending until the frame boundary.
        run(FRAME / 2);
        clear_stats();
        step(1'b1, 16'h4B00);
        check("flip_pending_set", flip_pending, 1);
        run_to(0, 0);
        check("single_flip_done", n_done, 1);
        step(1'b0, 16'h0000);
        check("new_frame_addr", vram_addr, 16'h4B00);

        // Two requests in a frame: the later one wins.
        clear_stats();
        run_to(0, 3);
        step(1'b1, 16'h1000);
        run_to(0, 8);
        step(1'b1, 16'h2000);
        check("pending_second_req", flip_pending, 1);
        run_to(0, 0);
        check("latest_wins_done", n_done, 1);
        step(1'b0, 16'h0000);
        check("latest_wins_addr", vram_addr, 16'h2000);

        // Request on the flip point itself; base near the top exercises address wrap.
        run_to(HT - 1, VT - 1);
        step(1'b1, 16'hFFFE);
        check("fp_req_done", flip_done, 1);
        check("fp_req_not_pending", flip_pending, 0);
        step(1'b0, 16'h0000);
        check("fp_req_addr", vram_addr, 16'hFFFE);
        run_to(16, 0);
        step(1'b0, 16'h0000);
        check("addr_wrap", vram_addr, 16'h0000);

        // Reset during hsync/vsync low with a flip pending.
        run_to(0, 5);
        step(1'b1, 16'h0777);
        run_to(42, 15);
        check("pending_before_reset", flip_pending, 1);
        do_reset(2);
        run(2);
        check("post_reset_active_early", in_active_area, 0);
        step(1'b0, 16'h0000);
        check("post_reset_first_active", in_active_area, 1);
        check("post_reset_base", vram_addr, 16'h0000);
        run(FRAME + 4);
        check("post_reset_no_flip", flip_pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
